// File: rtl/adder_seq_ctrl.sv
// Pops two little-endian operands from the RX FIFO, adds them and pushes the
// (OP_BYTES+1)-byte little-endian sum to the TX FIFO; counts completed operations.
module adder_seq_ctrl #(
  parameter int OP_BYTES = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  output logic             rx_rd_en,
  input  logic [7:0]       rx_data,
  input  logic             tx_full,
  output logic             tx_wr_en,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] op_count
);

  localparam int SW    = 8 * OP_BYTES;
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] NB       = IDX_W'(OP_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * OP_BYTES - 1);

  typedef enum logic [1:0] {RD_REQ, RD_CAP, ADD, WR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_widx;
  logic [IDX_W-1:0]  w_bidx;
  logic [SW-1:0]     r_a;
  logic [SW-1:0]     r_b;
  logic [SW:0]       r_sum;
  logic [SW+7:0]     w_sum_ext;
  logic [CNT_W-1:0]  r_cnt;

  assign w_bidx    = r_idx - NB;
  // Padding lets the top result byte read zeros above the carry bit.
  assign w_sum_ext = {7'd0, r_sum};

  always_ff @(posedge clk) begin
    if (rst) r_state <= RD_REQ;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    rx_rd_en = 1'b0;
    tx_wr_en = 1'b0;
    tx_data  = 8'd0;
    done     = 1'b0;
    case (r_state)
      RD_REQ: begin
        if (!rx_empty) begin
          rx_rd_en = 1'b1;
          w_next   = RD_CAP;
        end
      end
      RD_CAP: w_next = (r_idx == LAST_IDX) ? ADD : RD_REQ;
      ADD:    w_next = WR;
      WR: begin
        tx_data = w_sum_ext[{r_widx, 3'b000} +: 8];
        if (!tx_full) begin
          tx_wr_en = 1'b1;
          if (r_widx == NB) begin
            done   = 1'b1;
            w_next = RD_REQ;
          end
        end
      end
      default: w_next = RD_REQ;
    endcase
    if (rst) begin
      rx_rd_en = 1'b0;
      tx_wr_en = 1'b0;
      tx_data  = 8'd0;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= '0;
      r_widx <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        RD_CAP: begin
          if (r_idx < NB) r_a[{r_idx, 3'b000} +: 8]  <= rx_data;
          else            r_b[{w_bidx, 3'b000} +: 8] <= rx_data;
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        ADD: begin
          r_sum  <= {1'b0, r_a} + {1'b0, r_b};
          r_widx <= '0;
        end
        WR: begin
          if (!tx_full) begin
            if (r_widx == NB) r_cnt  <= r_cnt + CNT_W'(1);
            else              r_widx <= r_widx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = rst ? 1'b0 : ((r_state != RD_REQ) || (r_idx != '0));
  assign op_count = r_cnt;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: a wide-counter DUT plus a CNT_W=2 twin on shared stimulus.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_full = 1'b0;
  logic        rx_rd_en, tx_wr_en, busy, done;
  logic [7:0]  tx_data;
  logic [15:0] op_count;
  logic        n_rx_rd_en, n_tx_wr_en, n_busy, n_done;
  logic [7:0]  n_tx_data;
  logic [1:0]  n_op_count;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] rxq[$];
  int         checks = 0;
  int         failures = 0;
  int         exp_cnt = 0;
  logic       rd_seen;

  always #5 clk = ~clk;

  adder_seq_ctrl dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_rd_en(rx_rd_en), .rx_data(rx_data),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_data(tx_data), .busy(busy), .done(done),
    .op_count(op_count)
  );

  adder_seq_ctrl #(.OP_BYTES(2), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_rd_en(n_rx_rd_en), .rx_data(rx_data),
    .tx_full(tx_full), .tx_wr_en(n_tx_wr_en), .tx_data(n_tx_data), .busy(n_busy), .done(n_done),
    .op_count(n_op_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Non-FWFT RX FIFO model: data appears the cycle after the read strobe.
  always begin
    @(negedge clk);
    rd_seen = rx_rd_en;
    @(posedge clk);
    #1;
    if (rd_seen && rxq.size() > 0) rx_data = rxq.pop_front();
    rx_empty = (rxq.size() == 0);
  end

  // Monitor: every TX write pops the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_rd_en) chk("rd_while_empty", {31'd0, rx_empty}, 32'd0);
      if (tx_wr_en) begin
        if (sbq.size() == 0) begin
          chk("unexpected_tx_write", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, e.b});
          chk("done_on_write", {31'd0, done}, {31'd0, e.last});
          if (e.last) exp_cnt++;
        end
      end else if (done) begin
        chk("done_without_write", {31'd0, done}, 32'd0);
      end
    end
  end

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic push_exp(input logic [23:0] s);
    exp_t e;
    logic [23:0] v;
    v = s;
    for (int i = 0; i < 3; i++) begin
      e.b    = v[8*i +: 8];
      e.last = (i == 2);
      sbq.push_back(e);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [23:0] s);
    @(negedge clk);
    push_exp(s);
    push_rx(a[7:0]); push_rx(a[15:8]); push_rx(b[7:0]); push_rx(b[15:8]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) chk({name, "_timeout"}, sbq.size(), 32'd0);
    @(negedge clk);
    chk({name, "_op_count"}, {16'd0, op_count}, exp_cnt & 32'hFFFF);
    chk({name, "_op_count_w2"}, {30'd0, n_op_count}, exp_cnt & 32'h3);
    chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rx_drained();
    int n;
    n = 0;
    while (rxq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rxq.size() != 0) chk("rx_drain_timeout", rxq.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_rd_en"}, {31'd0, rx_rd_en}, 32'd0);
    chk({name, "_wr_en"}, {31'd0, tx_wr_en}, 32'd0);
    chk({name, "_done"},  {31'd0, done}, 32'd0);
    chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    chk({name, "_tx_data"}, {24'd0, tx_data}, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en_empty", {31'd0, rx_rd_en}, 32'd0);

    // Basic add: 0x1234 + 0x4321
    run_op(16'h1234, 16'h4321, 24'h00_5555);
    wait_drain("basic");

    // Carry into the third byte
    run_op(16'hFFFF, 16'h0001, 24'h01_0000);
    wait_drain("overflow");

    // RX starvation between 2nd and 3rd bytes
    @(negedge clk);
    push_exp(24'h00_5555);
    push_rx(8'h34); push_rx(8'h12);
    wait_rx_drained();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_rd_en", {31'd0, rx_rd_en}, 32'd0);
      chk("starve_busy", {31'd0, busy}, 32'd1);
    end
    push_rx(8'h21); push_rx(8'h43);
    wait_drain("starve");

    // TX backpressure after the first result byte; also wraps the 2-bit counter 3->0
    run_op(16'h0102, 16'h0304, 24'h00_0406);
    n = 0;
    while (!tx_wr_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!tx_wr_en) chk("bp_first_write_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_stall_wr_en", {31'd0, tx_wr_en}, 32'd0);
      chk("bp_stall_tx_data", {24'd0, tx_data}, 32'h04);
      chk("bp_stall_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk);
    #1 tx_full = 1'b0;
    wait_drain("backpressure");

    // Reset with 3 of 4 operand bytes loaded
    @(negedge clk);
    push_rx(8'hAA); push_rx(8'hBB); push_rx(8'hCC);
    wait_rx_drained();
    chk("partial_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_reset_outputs("mid_rst");
    end
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    run_op(16'h0001, 16'h0002, 24'h00_0003);
    wait_drain("after_reset");

    // Three operations queued back-to-back
    @(negedge clk);
    run_op(16'h0001, 16'h0001, 24'h00_0002);
    run_op(16'h8000, 16'h8000, 24'h01_0000);
    run_op(16'hABCD, 16'h1111, 24'h00_BCDE);
    wait_drain("back_to_back");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
